// File: rtl/error_arbiter.sv
// Error-line scheduler: three sticky pending classes, fixed priority grant,
// serial pulse codes with a guaranteed low gap, saturating merge counters.

module error_arbiter_mcnt #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr_i,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] cnt_o
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)                  cnt_d = '0;
    else if (inc_i && ~&cnt_q)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;
endmodule

module error_arbiter #(
  parameter int GAP_LENGTH = 4,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pending_err,
  input  logic                 evtno_err,
  input  logic                 spillno_err,
  input  logic                 stop_rising,
  input  logic                 stop_falling,
  input  logic                 eneword_err,
  input  logic                 cnt_clr,
  output logic                 err_out,
  output logic                 busy,
  output logic [1:0]           cur_level,
  output logic [2:0]           pend_vec,
  output logic [CNT_WIDTH-1:0] merge_cnt0,
  output logic [CNT_WIDTH-1:0] merge_cnt1,
  output logic [CNT_WIDTH-1:0] merge_cnt2
);
  localparam int         NUM_CLS = 3;
  localparam logic [3:0] GAP_L   = 4'(GAP_LENGTH);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e                             state_q;
  logic [1:0]                         cnt_q;
  logic [3:0]                         gcnt_q;
  logic [NUM_CLS-1:0]                 pend_q, pend_d, set_vec, clr_vec, inc_vec;
  logic [1:0]                         gnt_lvl;
  logic                               grant_pt;
  logic [NUM_CLS-1:0][CNT_WIDTH-1:0]  mcnt;

  always_comb begin
    set_vec  = {eneword_err, stop_rising | stop_falling,
                pending_err | evtno_err | spillno_err};
    grant_pt = (state_q == IDLE) || (state_q == GAP && gcnt_q == GAP_L);
    gnt_lvl  = 2'd0;
    clr_vec  = '0;
    if (grant_pt) begin
      if      (pend_q[0]) begin gnt_lvl = 2'd0; clr_vec = 3'b001; end
      else if (pend_q[1]) begin gnt_lvl = 2'd1; clr_vec = 3'b010; end
      else if (pend_q[2]) begin gnt_lvl = 2'd2; clr_vec = 3'b100; end
    end
    // a fresh event on the grant edge re-arms the class it just cleared
    pend_d  = (pend_q & ~clr_vec) | set_vec;
    inc_vec = set_vec & pend_q & ~clr_vec;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) pend_q <= '0;
    else        pend_q <= pend_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      err_out   <= 1'b0;
      busy      <= 1'b0;
      cur_level <= 2'd0;
      cnt_q     <= 2'd0;
      gcnt_q    <= 4'd0;
    end else if (|clr_vec) begin
      state_q   <= SEND;
      err_out   <= 1'b1;
      busy      <= 1'b1;
      cur_level <= gnt_lvl;
      cnt_q     <= 2'd0;
    end else begin
      case (state_q)
        SEND:
          if (cnt_q == cur_level) begin
            state_q <= GAP;
            err_out <= 1'b0;
            gcnt_q  <= 4'd1;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        GAP:
          if (gcnt_q == GAP_L) begin
            state_q <= IDLE;
            busy    <= 1'b0;
          end else begin
            gcnt_q <= gcnt_q + 4'd1;
          end
        default: ;
      endcase
    end
  end

  for (genvar c = 0; c < NUM_CLS; c++) begin : g_mcnt
    error_arbiter_mcnt #(.CNT_WIDTH(CNT_WIDTH)) u_mcnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr_i (cnt_clr),
      .inc_i (inc_vec[c]),
      .cnt_o (mcnt[c])
    );
  end

  assign pend_vec   = pend_q;
  assign merge_cnt0 = mcnt[0];
  assign merge_cnt1 = mcnt[1];
  assign merge_cnt2 = mcnt[2];
endmodule

// File: tb/tb_error_arbiter.sv
// Randomised bench for error_arbiter: a timing-level reference model queues
// expected codes at grant time; a negedge monitor decodes err_out and checks.

module tb_error_arbiter;
  localparam int GAP  = 4;
  localparam int CW   = 8;
  localparam int MAXC = 255;

  logic          clk = 1'b0, rst_n = 1'b0;
  logic [5:0]    src = '0;
  logic          cnt_clr = 1'b0;
  logic          err_out, busy;
  logic [1:0]    cur_level;
  logic [2:0]    pend_vec;
  logic [CW-1:0] mc0, mc1, mc2;

  error_arbiter #(.GAP_LENGTH(GAP), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .pending_err(src[0]), .evtno_err(src[1]), .spillno_err(src[2]),
    .stop_rising(src[3]), .stop_falling(src[4]), .eneword_err(src[5]),
    .cnt_clr(cnt_clr), .err_out(err_out), .busy(busy), .cur_level(cur_level),
    .pend_vec(pend_vec), .merge_cnt0(mc0), .merge_cnt1(mc1), .merge_cnt2(mc2)
  );

  always #5 clk = ~clk;

  typedef struct { int lvl; int start; } code_t;
  code_t exp_q[$];
  code_t e;

  int errors = 0, checks = 0;
  int cyc = 0, free_at = 0, hi_end = -1, m_lvl = 0, g = -1;
  bit m_pend[3];
  int m_cnt[3];
  bit s[3];
  int run = 0, st = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: a class is granted whenever the line is free and it is
  // the lowest pending index; the line is then busy for level+1 high plus GAP low.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int c = 0; c < 3; c++) begin m_pend[c] = 0; m_cnt[c] = 0; end
      free_at = 0; hi_end = -1; m_lvl = 0;
      exp_q.delete();
    end else begin
      cyc++;
      s[0] = src[0] | src[1] | src[2];
      s[1] = src[3] | src[4];
      s[2] = src[5];
      g = -1;
      if (cyc >= free_at)
        for (int c = 0; c < 3; c++) if (m_pend[c] && g < 0) g = c;
      if (g >= 0) begin
        exp_q.push_back('{g, cyc});
        free_at = cyc + g + 1 + GAP;
        hi_end  = cyc + g;
        m_lvl   = g;
      end
      for (int c = 0; c < 3; c++) begin
        if (cnt_clr) m_cnt[c] = 0;
        else if (s[c] && m_pend[c] && g != c && m_cnt[c] < MAXC) m_cnt[c]++;
        m_pend[c] = (m_pend[c] && g != c) || s[c];
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (!rst_n) run = 0;
    else begin
      chk("pend_vec", int'(pend_vec), int'({m_pend[2], m_pend[1], m_pend[0]}));
      chk("merge_cnt0", int'(mc0), m_cnt[0]);
      chk("merge_cnt1", int'(mc1), m_cnt[1]);
      chk("merge_cnt2", int'(mc2), m_cnt[2]);
      chk("busy", int'(busy), int'(cyc < free_at));
      chk("cur_level", int'(cur_level), m_lvl);
      chk("err_out", int'(err_out), int'(cyc <= hi_end));
      if (err_out) begin
        if (run == 0) st = cyc;
        run++;
      end else if (run > 0) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL code_unexpected: got level %0d at cycle %0d, expected none", run - 1, st);
        end else begin
          e = exp_q.pop_front();
          chk("code_level", run - 1, e.lvl);
          chk("code_start", st, e.start);
        end
        run = 0;
      end
    end
  end

  task automatic step(input logic [5:0] v, input logic clr);
    src = v; cnt_clr = clr;
    @(negedge clk);
    src = '0; cnt_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    logic [5:0] rv;
    int w;
    repeat (3) @(negedge clk);
    chk("rst_err_out", int'(err_out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_pend", int'(pend_vec), 0);
    chk("rst_level", int'(cur_level), 0);
    chk("rst_cnt", int'(mc0) + int'(mc1) + int'(mc2), 0);
    #2 rst_n = 1'b1;
    idle(3);

    step(6'b100000, 1'b0);                 // single warning
    idle(20);
    step(6'b101010, 1'b0);                 // one source of every class
    idle(30);

    step(6'b100000, 1'b0);                 // occupy the line, then merge STOP
    repeat (5) step(6'b010000, 1'b0);
    idle(1);
    chk("merge_cnt1_four", int'(mc1), 4);
    idle(15);
    step(6'b000000, 1'b1);
    chk("merge_cnt1_clr", int'(mc1), 0);

    step(6'b000001, 1'b0);                 // set/clear collision on grant edge
    step(6'b000100, 1'b0);
    chk("collision_pend0", int'(pend_vec[0]), 1);
    idle(20);

    repeat (400) step({3'b000, 3'($urandom_range(1, 7))}, 1'b0);
    chk("sat_cnt0", int'(mc0), MAXC);
    idle(20);
    chk("sat_cnt0_hold", int'(mc0), MAXC);

    step(6'b100000, 1'b0);                 // reset during a level-2 code
    @(posedge clk); @(posedge clk);
    #1 chk("pre_rst_err", int'(err_out), 1);
    #1 rst_n = 1'b0;
    #1 chk("midrst_err", int'(err_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pend", int'(pend_vec), 0);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b1;
    idle(10);
    chk("postrst_busy", int'(busy), 0);
    chk("postrst_pend", int'(pend_vec), 0);

    repeat (600) begin
      rv = '0;
      for (int b = 0; b < 6; b++) rv[b] = ($urandom_range(0, 7) == 0);
      step(rv, $urandom_range(0, 49) == 0);
    end

    w = 0;
    while ((exp_q.size() != 0 || busy || pend_vec != 0) && w < 300) begin
      @(negedge clk); w++;
    end
    chk("drain_in_time", int'(w < 300), 1);
    idle(5);
    chk("queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
